muldiv_unit: RTL and testbench

Iterative, parametrised multiply/divide unit that replaces the single-cycle `*`, `/`, `%` paths of the CPU's ALU. It accepts one operation at a time through a valid/ready handshake, computes over XLEN+1 cycles using one shift-add or restoring-divide step per cycle, and returns a registered result with a one-cycle valid pulse. The CPU stalls its PC while the unit is busy. Divide-by-zero and signed overflow follow RISC-V M-extension semantics.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_step.sv | 60 ++++++
 rtl/muldiv_unit.sv | 210 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared definitions for the iterative multiply/divide unit.
//             ALU opcode constants (shared with the ALU decoder), FSM state
//             encoding and an opcode legality helper.
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [5:0] ALU_OPCODE_MUL  = 6'd3;
    localparam logic [5:0] ALU_OPCODE_DIV  = 6'd10;
    localparam logic [5:0] ALU_OPCODE_DIVU = 6'd13;
    localparam logic [5:0] ALU_OPCODE_REM  = 6'd15;
    localparam logic [5:0] ALU_OPCODE_REMU = 6'd17;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == ALU_OPCODE_MUL)  || (op == ALU_OPCODE_DIV) ||
               (op == ALU_OPCODE_DIVU) || (op == ALU_OPCODE_REM) ||
               (op == ALU_OPCODE_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_step
//  Purpose  : One combinational iteration of the multiply/divide datapath.
//             mul mode : acc += a if b[0]; a <<= 1; b >>= 1
//             div mode : restoring step; acc is the partial remainder, a is
//                        the dividend being shifted out / quotient shifted in,
//                        b is the divisor magnitude (unchanged).
//  Ports    : div_mode_i        select restoring-divide step
//             acc_i/a_i/b_i     current datapath registers
//             acc_o/a_o/b_o     next datapath values
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            div_mode_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] a_o,
    output logic [XLEN-1:0] b_o
);

    logic [XLEN-1:0] w_sum;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;

    assign w_sum    = acc_i + a_i;
    // Partial remainder is kept below the divisor, so the shifted value fits
    // in XLEN+1 bits and the top bit of the difference is the borrow.
    assign w_rem_sh = {acc_i, a_i[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, b_i};

    always_comb begin
        acc_o = acc_i;
        a_o   = a_i;
        b_o   = b_i;
        if (div_mode_i) begin
            if (!w_diff[XLEN]) begin
                acc_o = w_diff[XLEN-1:0];
                a_o   = {a_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = w_rem_sh[XLEN-1:0];
                a_o   = {a_i[XLEN-2:0], 1'b0};
            end
        end else begin
            if (b_i[0]) begin
                acc_o = w_sum;
            end
            a_o = {a_i[XLEN-2:0], 1'b0};
            b_o = {1'b0, b_i[XLEN-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative multiply / divide / remainder unit with RISC-V M
//             semantics for divide-by-zero and signed overflow. One operation
//             in flight; XLEN iteration steps plus one sign-fix cycle.
//  Ports    : clk, rst (async, active-low)
//             in_valid/in_ready/in_op/in_a/in_b   request handshake
//             kill                                abort in-flight operation
//             out_valid/out_result/out_err        registered completion
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            kill,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic            out_err
);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              is_div_q, is_div_d;
    logic              is_rem_q, is_rem_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    // spec_q: DONE was entered straight from accept; acc_q holds the result
    // and it is presented one cycle later.
    logic              spec_q, spec_d;
    logic              spec_err_q, spec_err_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_result_q, out_result_d;
    logic              out_err_q, out_err_d;

    logic              w_accept, w_legal, w_op_mul, w_op_signed, w_op_rem;
    logic              w_a_neg, w_b_neg, w_div_zero, w_ovf, w_special;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_spec_res;
    logic [XLEN-1:0]   w_acc, w_a, w_b;

    assign in_ready    = (state_q == IDLE) || (state_q == DONE);
    assign w_accept    = in_valid && in_ready && !kill;
    assign w_legal     = op_is_legal(in_op);
    assign w_op_mul    = (in_op == ALU_OPCODE_MUL);
    assign w_op_signed = (in_op == ALU_OPCODE_DIV) || (in_op == ALU_OPCODE_REM);
    assign w_op_rem    = (in_op == ALU_OPCODE_REM) || (in_op == ALU_OPCODE_REMU);
    assign w_a_neg     = w_op_signed && in_a[XLEN-1];
    assign w_b_neg     = w_op_signed && in_b[XLEN-1];
    assign w_a_mag     = w_a_neg ? -in_a : in_a;
    assign w_b_mag     = w_b_neg ? -in_b : in_b;
    assign w_div_zero  = !w_op_mul && (in_b == '0);
    assign w_ovf       = w_op_signed && (in_a == MIN_VAL) && (in_b == '1);
    assign w_special   = !w_legal || w_div_zero || w_ovf;

    always_comb begin
        w_spec_res = '0;
        if (!w_legal) begin
            w_spec_res = '0;
        end else if (w_div_zero) begin
            w_spec_res = w_op_rem ? in_a : '1;
        end else if (w_ovf) begin
            w_spec_res = w_op_rem ? '0 : MIN_VAL;
        end
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div_mode_i (is_div_q),
        .acc_i      (acc_q),
        .a_i        (a_q),
        .b_i        (b_q),
        .acc_o      (w_acc),
        .a_o        (w_a),
        .b_o        (w_b)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        a_d          = a_q;
        b_d          = b_q;
        is_div_d     = is_div_q;
        is_rem_d     = is_rem_q;
        neg_quo_d    = neg_quo_q;
        neg_rem_d    = neg_rem_q;
        spec_d       = spec_q;
        spec_err_d   = spec_err_q;
        out_valid_d  = 1'b0;
        out_result_d = out_result_q;
        out_err_d    = out_err_q;

        case (state_q)
            IDLE: state_d = IDLE;
            MUL, DIV: begin
                acc_d = w_acc;
                a_d   = w_a;
                b_d   = w_b;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                out_valid_d = 1'b1;
                out_err_d   = 1'b0;
                if (!is_div_q) begin
                    out_result_d = acc_q;
                end else if (is_rem_q) begin
                    out_result_d = neg_rem_q ? -acc_q : acc_q;
                end else begin
                    out_result_d = neg_quo_q ? -a_q : a_q;
                end
                state_d = DONE;
            end
            DONE: begin
                if (spec_q) begin
                    out_valid_d  = 1'b1;
                    out_result_d = acc_q;
                    out_err_d    = spec_err_q;
                end
                spec_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Accept overrides the datapath load; the DONE emission above only
        // touches the output registers, so back-to-back issue is safe.
        if (w_accept) begin
            spec_d     = w_special;
            spec_err_d = !w_legal;
            acc_d      = w_special ? w_spec_res : '0;
            a_d        = w_op_mul ? in_a : w_a_mag;
            b_d        = w_op_mul ? in_b : w_b_mag;
            is_div_d   = !w_op_mul;
            is_rem_d   = w_op_rem;
            neg_quo_d  = w_a_neg ^ w_b_neg;
            neg_rem_d  = w_a_neg;
            cnt_d      = CNT_W'(XLEN);
            if (w_special) begin
                state_d = DONE;
            end else begin
                state_d = w_op_mul ? MUL : DIV;
            end
        end

        if (kill) begin
            state_d      = IDLE;
            spec_d       = 1'b0;
            out_valid_d  = 1'b0;
            out_result_d = out_result_q;
            out_err_d    = out_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            is_div_q     <= 1'b0;
            is_rem_q     <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            spec_q       <= 1'b0;
            spec_err_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            a_q          <= a_d;
            b_q          <= b_d;
            is_div_q     <= is_div_d;
            is_rem_q     <= is_rem_d;
            neg_quo_q    <= neg_quo_d;
            neg_rem_q    <= neg_rem_d;
            spec_q       <= spec_d;
            spec_err_q   <= spec_err_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_err_q    <= out_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_err    = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Directed self-checking bench for muldiv_unit (XLEN=64 and 32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        v64, v32, kill;
    logic [5:0]  op;
    logic [63:0] a64, b64;
    logic [31:0] a32, b32;
    logic        rdy64, ov64, err64;
    logic [63:0] r64;
    logic        rdy32, ov32, err32;
    logic [31:0] r32;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64), .in_op(op),
        .in_a(a64), .in_b(b64), .kill(kill), .out_valid(ov64),
        .out_result(r64), .out_err(err64)
    );

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .in_op(op),
        .in_a(a32), .in_b(b32), .kill(kill), .out_valid(ov32),
        .out_result(r32), .out_err(err32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive a request now, let it be accepted on the next rising edge.
    task automatic issue(input bit w32, input logic [5:0] o, input logic [63:0] a, input logic [63:0] b);
        op = o;
        if (w32) begin
            a32 = a[31:0]; b32 = b[31:0]; v32 = 1'b1;
            check("in_ready32_before_accept", {63'd0, rdy32}, 64'd1);
        end else begin
            a64 = a; b64 = b; v64 = 1'b1;
            check("in_ready64_before_accept", {63'd0, rdy64}, 64'd1);
        end
        @(posedge clk);
        #1;
        v32 = 1'b0;
        v64 = 1'b0;
        a64 = '0; b64 = '0; a32 = '0; b32 = '0; op = 6'd0;
    endtask

    task automatic wait_result(input bit w32, input string tag, input logic [63:0] exp_res,
                               input int exp_lat, input bit exp_err);
        int  n    = 0;
        bit  seen = 1'b0;
        while (n < 200 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            seen = w32 ? ov32 : ov64;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_result"}, w32 ? {32'd0, r32} : r64, exp_res);
        check({tag, "_err"}, {63'd0, (w32 ? err32 : err64)}, {63'd0, exp_err});
    endtask

    task automatic run_op(input bit w32, input logic [5:0] o, input logic [63:0] a,
                          input logic [63:0] b, input string tag, input logic [63:0] exp_res,
                          input int exp_lat, input bit exp_err);
        @(negedge clk);
        issue(w32, o, a, b);
        wait_result(w32, tag, exp_res, exp_lat, exp_err);
        @(posedge clk);
        #1;
        check({tag, "_pulse_low"}, {63'd0, (w32 ? ov32 : ov64)}, 64'd0);
    endtask

    initial begin
        bit saw;
        rst = 1'b0; v64 = 1'b0; v32 = 1'b0; kill = 1'b0; op = 6'd0;
        a64 = '0; b64 = '0; a32 = '0; b32 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {63'd0, rdy64}, 64'd1);
        check("reset_out_valid", {63'd0, ov64}, 64'd0);
        check("reset_out_result", r64, 64'd0);
        check("reset_out_err", {63'd0, err64}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op(0, ALU_OPCODE_MUL,  64'd7, 64'd6, "mul_7x6", 64'd42, 65, 1'b0);
        run_op(0, ALU_OPCODE_MUL,  -64'sd3, 64'd5, "mul_m3x5", 64'hFFFF_FFFF_FFFF_FFF1, 65, 1'b0);
        run_op(0, ALU_OPCODE_DIV,  -64'sd7, 64'd2, "div_m7_2", 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0);
        run_op(0, ALU_OPCODE_REM,  -64'sd7, 64'd2, "rem_m7_2", 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
        run_op(0, ALU_OPCODE_DIVU, 64'd100, 64'd7, "divu_100_7", 64'd14, 65, 1'b0);
        run_op(0, ALU_OPCODE_REMU, 64'd100, 64'd7, "remu_100_7", 64'd2, 65, 1'b0);

        // kill in cycle 20 of a divide; the last result (2) must be kept
        @(negedge clk);
        issue(0, ALU_OPCODE_DIV, 64'd1000, 64'd3);
        repeat (18) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_in_ready", {63'd0, rdy64}, 64'd1);
        check("kill_out_valid", {63'd0, ov64}, 64'd0);
        check("kill_out_result", r64, 64'd2);
        saw = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            saw |= ov64;
        end
        check("kill_no_late_valid", {63'd0, saw}, 64'd0);
        check("kill_result_held", r64, 64'd2);

        run_op(0, ALU_OPCODE_DIVU, 64'd5, 64'd0, "divu_by_zero", 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
        run_op(0, ALU_OPCODE_REM,  64'd5, 64'd0, "rem_by_zero", 64'd5, 1, 1'b0);

        // 32-bit instance: zero-bubble back-to-back, then illegal opcode
        @(negedge clk);
        issue(1, ALU_OPCODE_MUL, 64'd3, 64'd4);
        wait_result(1, "b2b_mul32", 64'd12, 33, 1'b0);
        issue(1, ALU_OPCODE_DIVU, 64'd9, 64'd2);
        wait_result(1, "b2b_divu32", 64'd4, 33, 1'b0);
        run_op(1, 6'd1, 64'd5, 64'd5, "illegal32", 64'd0, 1, 1'b1);

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        issue(0, ALU_OPCODE_MUL, 64'd7, 64'd6);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_in_ready", {63'd0, rdy64}, 64'd1);
        check("async_rst_out_valid", {63'd0, ov64}, 64'd0);
        check("async_rst_out_result", r64, 64'd0);
        check("async_rst_out_err32", {63'd0, err32}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op(0, ALU_OPCODE_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               "div_overflow", 64'h8000_0000_0000_0000, 1, 1'b0);
        run_op(0, ALU_OPCODE_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               "rem_overflow", 64'd0, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
